// File: rtl/alu_exec_stage.sv
// Single-cycle ALU execute stage (add/sub and bitwise ops) feeding a 2-entry result FIFO.
// in_ready is registered from the next occupancy, so out_ready never reaches it combinationally.
module alu_exec_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            uop_is_add,
  input  logic [1:0]      ctrl_adder,
  input  logic            uop_is_logic,
  input  logic [2:0]      ctrl_logic,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [11:0]     imm12,
  input  logic [4:0]      rd_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd_tag,
  output logic            out_zero,
  output logic            out_illegal
);

  logic [XLEN-1:0] w_imm_ext;
  logic [XLEN-1:0] w_result;
  logic            w_illegal;
  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_count_nxt;

  logic [XLEN-1:0] r_mem_res [DEPTH];
  logic [4:0]      r_mem_tag [DEPTH];
  logic            r_mem_zero[DEPTH];
  logic            r_mem_ill [DEPTH];
  logic            r_wptr;
  logic            r_rptr;
  logic [1:0]      r_count;
  logic            r_in_ready;

  assign w_imm_ext = {{(XLEN-12){imm12[11]}}, imm12};

  always_comb begin
    w_illegal = 1'b0;
    w_result  = '0;
    if (uop_is_add == uop_is_logic) begin
      w_illegal = 1'b1;
    end else if (uop_is_add) begin
      case (ctrl_adder)
        2'b01:   w_result = rs1_data + rs2_data;
        2'b10:   w_result = rs1_data - rs2_data;
        2'b11:   w_result = rs1_data + w_imm_ext;
        default: w_illegal = 1'b1;
      endcase
    end else begin
      case (ctrl_logic)
        3'b001:  w_result = rs1_data | rs2_data;
        3'b010:  w_result = rs1_data ^ rs2_data;
        3'b011:  w_result = rs1_data & rs2_data;
        3'b100:  w_result = rs1_data | w_imm_ext;
        3'b101:  w_result = rs1_data ^ w_imm_ext;
        3'b110:  w_result = rs1_data & w_imm_ext;
        default: w_illegal = 1'b1;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_count != 2'd0);
  assign out_result  = r_mem_res[r_rptr];
  assign out_rd_tag  = r_mem_tag[r_rptr];
  assign out_zero    = r_mem_zero[r_rptr];
  assign out_illegal = r_mem_ill[r_rptr];

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = out_valid & out_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem_res[i]  <= '0;
        r_mem_tag[i]  <= '0;
        r_mem_zero[i] <= 1'b0;
        r_mem_ill[i]  <= 1'b0;
      end
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem_res[r_wptr]  <= w_result;
        r_mem_tag[r_wptr]  <= rd_tag;
        r_mem_zero[r_wptr] <= (w_result == '0);
        r_mem_ill[r_wptr]  <= w_illegal;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt < 2'(DEPTH));
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: arithmetic/logic vectors, illegal encodings,
// backpressure ordering and asynchronous reset while entries are buffered.
module tb_alu_exec_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        uop_is_add;
  logic [1:0]  ctrl_adder;
  logic        uop_is_logic;
  logic [2:0]  ctrl_logic;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [11:0] imm12;
  logic [4:0]  rd_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd_tag;
  logic        out_zero;
  logic        out_illegal;

  int n_checks;
  int n_fail;

  typedef struct packed {
    logic        isadd;
    logic [1:0]  ca;
    logic        islog;
    logic [2:0]  cl;
    logic [31:0] a;
    logic [31:0] b;
    logic [11:0] imm;
    logic [4:0]  rd;
    logic [31:0] exp;
    logic        ill;
  } vec_t;

  alu_exec_stage #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .uop_is_add(uop_is_add), .ctrl_adder(ctrl_adder),
    .uop_is_logic(uop_is_logic), .ctrl_logic(ctrl_logic),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm12(imm12), .rd_tag(rd_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd_tag(out_rd_tag),
    .out_zero(out_zero), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic isadd, input logic [1:0] ca, input logic islog,
                              input logic [2:0] cl, input logic [31:0] a, input logic [31:0] b,
                              input logic [11:0] imm, input logic [4:0] rd,
                              input logic [31:0] exp, input logic ill);
    vec_t v;
    v = '{isadd, ca, islog, cl, a, b, imm, rd, exp, ill};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    uop_is_add   = v.isadd;
    ctrl_adder   = v.ca;
    uop_is_logic = v.islog;
    ctrl_logic   = v.cl;
    rs1_data     = v.a;
    rs2_data     = v.b;
    imm12        = v.imm;
    rd_tag       = v.rd;
    in_valid     = 1'b1;
  endtask

  task automatic send(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_vectors(input vec_t vs[8], input int n, input string name);
    for (int i = 0; i < n; i++) begin
      send(vs[i]);
      n_checks += 5;
      if (out_valid !== 1'b1) begin
        n_fail++; $display("FAIL %s[%0d] out_valid got %b want 1", name, i, out_valid);
      end
      if (out_result !== vs[i].exp) begin
        n_fail++; $display("FAIL %s[%0d] out_result got %h want %h", name, i, out_result, vs[i].exp);
      end
      if (out_rd_tag !== vs[i].rd) begin
        n_fail++; $display("FAIL %s[%0d] out_rd_tag got %0d want %0d", name, i, out_rd_tag, vs[i].rd);
      end
      if (out_zero !== (vs[i].exp == 32'd0)) begin
        n_fail++; $display("FAIL %s[%0d] out_zero got %b want %b", name, i, out_zero, vs[i].exp == 32'd0);
      end
      if (out_illegal !== vs[i].ill) begin
        n_fail++; $display("FAIL %s[%0d] out_illegal got %b want %b", name, i, out_illegal, vs[i].ill);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    uop_is_add = 1'b0; ctrl_adder = '0; uop_is_logic = 1'b0; ctrl_logic = '0;
    rs1_data = '0; rs2_data = '0; imm12 = '0; rd_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready got %b want 0", in_ready); end
    if (out_result !== 32'd0) begin n_fail++; $display("FAIL reset out_result got %h want 0", out_result); end
    if ({out_rd_tag, out_zero, out_illegal} !== 7'd0) begin
      n_fail++; $display("FAIL reset out_flags got %h want 0", {out_rd_tag, out_zero, out_illegal});
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks += 2;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release out_valid got %b want 0", out_valid); end
  endtask

  // out_ready held high: each send pops the previous head and pushes the new uop.
  task automatic test_arith_logic();
    vec_t vs[8];
    out_ready = 1'b1;
    vs[0] = mk(1, 2'b01, 0, 3'b000, 32'h7FFFFFFF, 32'h00000001, 12'h000, 5'd3, 32'h80000000, 0);
    vs[1] = mk(1, 2'b10, 0, 3'b000, 32'h00000005, 32'h00000005, 12'h000, 5'd7, 32'h00000000, 0);
    vs[2] = mk(1, 2'b11, 0, 3'b000, 32'h00000000, 32'h12345678, 12'hFFF, 5'd9, 32'hFFFFFFFF, 0);
    vs[3] = mk(0, 2'b00, 1, 3'b110, 32'hFFFF00FF, 32'h00000000, 12'h80F, 5'd10, 32'hFFFF000F, 0);
    vs[4] = mk(0, 2'b00, 1, 3'b010, 32'hA5A5A5A5, 32'hFFFFFFFF, 12'h000, 5'd11, 32'h5A5A5A5A, 0);
    vs[5] = mk(0, 2'b00, 1, 3'b001, 32'hF0F00000, 32'h0000F0F0, 12'h000, 5'd12, 32'hF0F0F0F0, 0);
    vs[6] = mk(0, 2'b00, 1, 3'b101, 32'hFFFFFFFF, 32'h00000000, 12'h800, 5'd13, 32'h000007FF, 0);
    vs[7] = mk(1, 2'b10, 0, 3'b000, 32'h00000000, 32'h00000001, 12'h000, 5'd31, 32'hFFFFFFFF, 0);
    run_vectors(vs, 8, "alu");
    vs[0] = mk(0, 2'b00, 1, 3'b100, 32'h12340000, 32'h00000000, 12'h0FF, 5'd14, 32'h123400FF, 0);
    vs[1] = mk(0, 2'b00, 1, 3'b011, 32'hFFFF0000, 32'h00FFFF00, 12'h000, 5'd15, 32'h00FF0000, 0);
    vs[2] = mk(1, 2'b01, 0, 3'b000, 32'hFFFFFFFF, 32'h00000002, 12'h000, 5'd16, 32'h00000001, 0);
    run_vectors(vs, 3, "alu2");
  endtask

  task automatic test_illegal();
    vec_t vs[8];
    out_ready = 1'b1;
    vs[0] = mk(1, 2'b01, 1, 3'b001, 32'h00000011, 32'h00000022, 12'h000, 5'd21, 32'h0, 1);
    vs[1] = mk(0, 2'b00, 1, 3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 12'hFFF, 5'd22, 32'h0, 1);
    vs[2] = mk(0, 2'b01, 0, 3'b001, 32'h00000003, 32'h00000004, 12'h000, 5'd23, 32'h0, 1);
    vs[3] = mk(1, 2'b00, 0, 3'b000, 32'h00000003, 32'h00000004, 12'h000, 5'd24, 32'h0, 1);
    vs[4] = mk(0, 2'b00, 1, 3'b000, 32'h00000003, 32'h00000004, 12'h000, 5'd25, 32'h0, 1);
    vs[5] = mk(1, 2'b01, 0, 3'b000, 32'h00000003, 32'h00000004, 12'h000, 5'd26, 32'h7, 0);
    run_vectors(vs, 6, "illegal");
  endtask

  task automatic test_back_to_back();
    vec_t v;
    logic [31:0] held;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain out_valid got %b want 0", out_valid); end
    out_ready = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      v = mk(1, 2'b01, 0, 3'b000, 32'(10 * i), 32'(i), 12'h000, 5'(i), 32'(11 * i), 0);
      send(v);
    end
    n_checks += 2;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b full in_ready got %b want 0", in_ready); end
    if (out_rd_tag !== 5'd1) begin n_fail++; $display("FAIL b2b head tag got %0d want 1", out_rd_tag); end
    held = out_result;
    // rd 3 offered while full: must not be taken
    @(negedge clk);
    drive(mk(1, 2'b01, 0, 3'b000, 32'd30, 32'd3, 12'h000, 5'd3, 32'd33, 0));
    @(posedge clk);
    #1;
    n_checks += 3;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b held in_ready got %b want 0", in_ready); end
    if (out_rd_tag !== 5'd1) begin n_fail++; $display("FAIL b2b stall tag got %0d want 1", out_rd_tag); end
    if (out_result !== 32'd11 || held !== 32'd11) begin
      n_fail++; $display("FAIL b2b stall result got %h want %h", out_result, 32'd11);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks += 3;
    if (out_rd_tag !== 5'd2) begin n_fail++; $display("FAIL b2b second tag got %0d want 2", out_rd_tag); end
    if (out_result !== 32'd22) begin n_fail++; $display("FAIL b2b second result got %h want %h", out_result, 32'd22); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b reopen in_ready got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks += 3;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b third valid got %b want 1", out_valid); end
    if (out_rd_tag !== 5'd3) begin n_fail++; $display("FAIL b2b third tag got %0d want 3", out_rd_tag); end
    if (out_result !== 32'd33) begin n_fail++; $display("FAIL b2b third result got %h want %h", out_result, 32'd33); end
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b empty valid got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    vec_t v;
    out_ready = 1'b0;
    send(mk(1, 2'b01, 0, 3'b000, 32'd40, 32'd4, 12'h000, 5'd4, 32'd44, 0));
    send(mk(1, 2'b01, 0, 3'b000, 32'd50, 32'd5, 12'h000, 5'd5, 32'd55, 0));
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid pre valid got %b want 1", out_valid); end
    #1;
    reset = 1'b0;
    #1;
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid in_ready got %b want 0", in_ready); end
    if (out_result !== 32'd0) begin n_fail++; $display("FAIL rstmid out_result got %h want 0", out_result); end
    if (out_rd_tag !== 5'd0) begin n_fail++; $display("FAIL rstmid out_rd_tag got %0d want 0", out_rd_tag); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks += 2;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid release in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid release valid got %b want 0", out_valid); end
    v = mk(1, 2'b11, 0, 3'b000, 32'd100, 32'd0, 12'h006, 5'd6, 32'd106, 0);
    send(v);
    n_checks += 2;
    if (out_rd_tag !== 5'd6) begin n_fail++; $display("FAIL rstmid new tag got %0d want 6", out_rd_tag); end
    if (out_result !== 32'd106) begin n_fail++; $display("FAIL rstmid new result got %h want %h", out_result, 32'd106); end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid alone valid got %b want 0", out_valid); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_arith_logic();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 Parameter XLEN, 32, operand/result width.
REQ-002 Parameter DEPTH, 2, output buffer entries; fixed at 2 in this release.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  uop presented.
REQ-006 in_ready  output  1  stage can accept the uop this cycle.
REQ-007 uop_is_add  input  1  uop uses the adder.
REQ-008 ctrl_adder  input  2  00 none, 01 ADD, 10 SUB, 11 ADDI.
REQ-009 uop_is_logic  input  1  uop uses the logic unit.
REQ-010 ctrl_logic  input  3  000 none, 001 OR, 010 XOR, 011 AND, 100 ORI, 101 XORI, 110 ANDI, 111 reserved.
REQ-011 rs1_data  input  XLEN  operand A.
REQ-012 rs2_data  input  XLEN  operand B for register forms.
REQ-013 imm12  input  12  immediate; sign-extended to XLEN for ADDI/ORI/XORI/ANDI.
REQ-014 rd_tag  input  5  destination register, carried with result.
REQ-015 out_valid  output  1  result available.
REQ-016 out_ready  input  1  consumer accepts result.
REQ-017 out_result  output  XLEN  computed result.
REQ-018 out_rd_tag  output  5  destination of out_result.
REQ-019 out_zero  output  1  out_result == 0.
REQ-020 out_illegal  output  1  uop encoding was illegal; out_result is 0.

Function
REQ-021 A uop is accepted when in_valid and in_ready are both high on a rising edge.
REQ-022 Operand B is rs2_data for ADD/SUB/OR/XOR/AND and sign-extended imm12 for ADDI/ORI/XORI/ANDI.
REQ-023 ADD/ADDI: A+B modulo 2^XLEN; SUB: A-B modulo 2^XLEN; carries and overflow are discarded.
REQ-024 OR/XOR/AND and immediate variants: bitwise A op B.
REQ-025 Illegal: both uop_is_add and uop_is_logic high; neither high; uop_is_add with ctrl_adder 00; uop_is_logic with ctrl_logic 000 or 111 -> entry stores result 0, out_illegal 1, rd_tag unchanged.
REQ-026 The result is computed combinationally at accept and written into a 2-entry FIFO together with rd_tag, zero flag and illegal flag.
REQ-027 Latency: an accepted uop appears on out_* in the cycle after the accepting edge when the buffer was empty.
REQ-028 Occupancy counter count (0..2): push only = +1, pop only = -1, push and pop together = unchanged.
REQ-029 Pop occurs when out_valid and out_ready are both high on a rising edge.
REQ-030 in_ready = (count < 2), driven from registered state only; no combinational path from out_ready to in_ready.
REQ-031 out_valid = (count != 0); out_* always shows the oldest entry.
REQ-032 Full (count 2) with out_ready high: pop occurs, no push that cycle, count becomes 1.
REQ-033 count 1 with simultaneous push and pop: head becomes the new uop, count stays 1.
REQ-034 out_* values are held stable while out_valid is high and out_ready is low.
REQ-035 Ordering is strictly FIFO; no entry is dropped or duplicated.
REQ-036 Input fields are ignored when in_valid is low or in_ready is low.

Reset
REQ-037 Assertion of reset (low), at any time including mid-transfer, immediately sets count 0, out_valid 0, in_ready 0 while asserted, and out_result, out_rd_tag, out_zero, out_illegal to 0; buffered entries are discarded.
REQ-038 First edge after reset release: in_ready 1, out_valid 0.

Verification
REQ-039 ADD rs1=0x7FFFFFFF, rs2=1, rd=3, out_ready=1 -> next cycle out_result=0x80000000, out_rd_tag=3, out_zero=0.
REQ-040 SUB rs1=5, rs2=5 -> out_result=0, out_zero=1; ADDI rs1=0, imm12=0xFFF -> out_result=0xFFFFFFFF.
REQ-041 ANDI rs1=0xFFFF00FF, imm12=0x80F -> out_result=0xFFFF000F; XOR rs1=0xA5A5A5A5, rs2=0xFFFFFFFF -> 0x5A5A5A5A.
REQ-042 out_ready=0, three back-to-back uops (rd 1,2,3) -> after two accepts in_ready=0, third held; raise out_ready -> results emerge rd 1,2,3 in order, none lost.
REQ-043 uop_is_add=1, uop_is_logic=1 -> out_illegal=1, out_result=0, rd_tag preserved; ctrl_logic=111 -> same.
REQ-044 Two entries buffered, reset asserted mid-cycle -> out_valid falls immediately; after release first uop accepted appears alone with 1-cycle latency.
